// File: rtl/serial_mag_comparator_if.sv
// Serial comparator bus: handshake inputs from the producer plus result outputs.
//   master : producer side (drives start/bit_valid/a_bit/b_bit, observes results)
//   slave  : comparator side (consumes the bit stream, drives status and results)
interface serial_mag_comparator_if #(
  parameter int unsigned WIDTH = 4
);

  logic             start;
  logic             bit_valid;
  logic             a_bit;
  logic             b_bit;
  logic             busy;
  logic             done;
  logic             result_valid;
  logic             a_gt_b;
  logic             a_eq_b;
  logic             a_lt_b;
  logic [WIDTH-1:0] a_word;
  logic [WIDTH-1:0] b_word;

  modport master (
    output start, bit_valid, a_bit, b_bit,
    input  busy, done, result_valid, a_gt_b, a_eq_b, a_lt_b, a_word, b_word
  );

  modport slave (
    input  start, bit_valid, a_bit, b_bit,
    output busy, done, result_valid, a_gt_b, a_eq_b, a_lt_b, a_word, b_word
  );

endinterface

// File: rtl/serial_mag_comparator.sv
// Bit-serial magnitude comparator. Two WIDTH-bit operands arrive LSB first, one
// bit pair per accepted beat; the block rebuilds both words and reports a
// one-hot A>B / A=B / A<B result with a single-cycle done pulse.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   bus (slave)       : start, bit_valid, a_bit, b_bit in;
//                       busy, done, result_valid, a_gt_b, a_eq_b, a_lt_b,
//                       a_word, b_word out (all registered)
module serial_mag_comparator #(
  parameter int unsigned WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  serial_mag_comparator_if.slave  bus
);

  localparam int unsigned     CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    REL_EQ = 2'd0,
    REL_GT = 2'd1,
    REL_LT = 2'd2
  } rel_e;

  state_e           state_q, state_d;
  rel_e             rel_q, rel_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_word_q, a_word_d;
  logic [WIDTH-1:0] b_word_q, b_word_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             rv_q, rv_d;
  logic             gt_q, gt_d;
  logic             eq_q, eq_d;
  logic             lt_q, lt_d;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      rel_q    <= REL_EQ;
      cnt_q    <= '0;
      a_word_q <= '0;
      b_word_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      rv_q     <= 1'b0;
      gt_q     <= 1'b0;
      eq_q     <= 1'b0;
      lt_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      rel_q    <= rel_d;
      cnt_q    <= cnt_d;
      a_word_q <= a_word_d;
      b_word_q <= b_word_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      rv_q     <= rv_d;
      gt_q     <= gt_d;
      eq_q     <= eq_d;
      lt_q     <= lt_d;
    end
  end

  // Next-state, bit capture and result loading
  always_comb begin
    state_d  = state_q;
    rel_d    = rel_q;
    cnt_d    = cnt_q;
    a_word_d = a_word_q;
    b_word_d = b_word_q;
    rv_d     = rv_q;
    gt_d     = gt_q;
    eq_d     = eq_q;
    lt_d     = lt_q;

    // start wins in every state; in SHIFT it aborts and restarts
    if (bus.start) begin
      state_d  = ST_SHIFT;
      rel_d    = REL_EQ;
      cnt_d    = '0;
      a_word_d = '0;
      b_word_d = '0;
      rv_d     = 1'b0;
      gt_d     = 1'b0;
      eq_d     = 1'b0;
      lt_d     = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          state_d = ST_IDLE;
        end
        ST_SHIFT: begin
          if (bus.bit_valid) begin
            a_word_d[cnt_q] = bus.a_bit;
            b_word_d[cnt_q] = bus.b_bit;
            // LSB first: each differing bit outranks all earlier ones
            if (bus.a_bit && !bus.b_bit) begin
              rel_d = REL_GT;
            end else if (!bus.a_bit && bus.b_bit) begin
              rel_d = REL_LT;
            end
            if (cnt_q == LAST_IDX) begin
              state_d = ST_DONE;
              cnt_d   = '0;
              rv_d    = 1'b1;
              gt_d    = (rel_d == REL_GT);
              eq_d    = (rel_d == REL_EQ);
              lt_d    = (rel_d == REL_LT);
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        ST_DONE: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    busy_d = (state_d == ST_SHIFT);
    done_d = (state_d == ST_DONE);
  end

  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.result_valid = rv_q;
  assign bus.a_gt_b       = gt_q;
  assign bus.a_eq_b       = eq_q;
  assign bus.a_lt_b       = lt_q;
  assign bus.a_word       = a_word_q;
  assign bus.b_word       = b_word_q;

endmodule

// File: doc/serial_mag_comparator.md
Name: serial_mag_comparator

Overview:
- Bit-serial magnitude comparator: the sequential counterpart of our parallel 2-bit comparator circuits.
- Two WIDTH-bit operands arrive one bit pair per accepted beat, LSB first, under a start/valid handshake.
- The block reconstructs both words and reports A>B / A=B / A<B as mutually exclusive one-hot flags with a done pulse.
- Intended as the front end for serial links that feed our compare/select logic.

Parameters:
WIDTH, 4, operand width in bits (>=2); also the number of bit beats per comparison.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
start  in  1  begin a new comparison (clears the accumulated result)
bit_valid  in  1  a_bit/b_bit carry a valid bit pair this cycle
a_bit  in  1  serial operand A bit, LSB first
b_bit  in  1  serial operand B bit, LSB first
busy  out  1  high while in SHIFT state
done  out  1  one-cycle pulse when the result is final
result_valid  out  1  high from done until the next start or reset
a_gt_b  out  1  A > B (valid when result_valid)
a_eq_b  out  1  A == B (valid when result_valid)
a_lt_b  out  1  A < B (valid when result_valid)
a_word  out  WIDTH  reconstructed operand A
b_word  out  WIDTH  reconstructed operand B

Behaviour:
- Reset (asynchronous, rst_n=0):
  - State goes to IDLE.
  - All outputs go to 0: busy, done, result_valid, the three flags, a_word, b_word.
  - Bit counter goes to 0.
  - Reset mid-SHIFT discards the partial comparison and produces no done.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - bit_valid is ignored.
  - start=1 -> SHIFT. At that edge: counter=0, relation=EQ, a_word=0, b_word=0, result_valid=0.
- SHIFT:
  - busy=1.
  - Each edge with bit_valid=1 accepts one bit pair:
    - a_word[counter]=a_bit, b_word[counter]=b_bit.
    - a_bit=1, b_bit=0 -> relation=GT.
    - a_bit=0, b_bit=1 -> relation=LT.
    - a_bit=b_bit -> relation unchanged.
    - The more significant bit always overrides, because bits arrive LSB first.
    - counter increments.
  - bit_valid=0 cycles (gaps) change nothing.
  - When the accepted bit is index WIDTH-1 -> DONE. At that same edge the flags are loaded from the final relation and a_word/b_word are complete.
- DONE (one cycle):
  - done=1, result_valid=1, busy=0.
  - Next state is IDLE unconditionally.
  - start in the DONE cycle -> SHIFT directly, with the same clearing as from IDLE.
  - bit_valid in the DONE cycle is ignored.
- Latency: done is high in the cycle after the edge that samples the WIDTH-th valid bit.
- Flags:
  - Exactly one of a_gt_b/a_eq_b/a_lt_b is high while result_valid=1.
  - All three are 0 while result_valid=0.
  - Flags and words hold their values in IDLE until the next start.
- start during SHIFT:
  - Abort and restart: counter=0, relation=EQ, words cleared, no done.
  - Any bit_valid in that same cycle is ignored.
- Counter width is clog2(WIDTH). It never exceeds WIDTH-1.

Test Plan:
- WIDTH=4, start, then 4 back-to-back beats with A=1010 (a: 0,1,0,1), B=0110 (b: 0,1,1,0) -> relation EQ,EQ,LT,GT; done one cycle after the 4th beat; a_gt_b=1; a_word=4'hA, b_word=4'h6; busy low in the DONE cycle.
- A=5, B=5 with bit_valid gaps of 0–3 cycles between beats -> a_eq_b=1, done exactly once, after the 4th valid beat only; no flags before then.
- A=3, B=12 -> a_lt_b=1; then start again with A=12, B=3 -> result_valid drops at start, and the new done gives a_gt_b=1.
- start after 2 beats of A=15, B=0, then a full A=0, B=15 sequence -> single done with a_lt_b=1 and a_word=0; the aborted pass produces no done.
- rst_n low asynchronously mid-SHIFT (between clock edges) -> all outputs 0 immediately; bit_valid pulses after release without start -> no change, busy stays 0.
- start asserted in the DONE cycle -> DONE goes straight to SHIFT; the next 4 beats complete normally. Also check one-hot flags on every cycle where result_valid=1.
